// File: rtl/cpu_pkg.sv
// Types, constants and helpers shared by the fetch/branch control logic.
package cpu_pkg;

    typedef enum logic {RUN, BR_WAIT} br_state_t;

    localparam int PC_STEP = 4;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational redirect targets for the ID-stage beq and j instructions.
module branch_target_calc
    import cpu_pkg::*;
(
    input  logic [31:0] idPc4,
    input  logic [15:0] idImm16,
    input  logic [25:0] idJidx,
    output logic [31:0] brTgt,
    output logic [31:0] jTgt
);

    // Carries out of bit 31 are dropped, so targets wrap modulo 2^32.
    assign brTgt = idPc4 + (sext16(idImm16) << 2);
    assign jTgt  = {idPc4[31:28], idJidx, 2'b00};

endmodule

// File: rtl/branch_pc_ctrl.sv
// PC register, next-PC selection and IF/ID control for beq/j redirects,
// with a hold state for branches whose operands are still being forwarded.
module branch_pc_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             id_is_beq,
    input  logic             id_is_j,
    input  logic             opnd_ready,
    input  logic             res_beq,
    input  logic [31:0]      id_pc4,
    input  logic [15:0]      id_imm16,
    input  logic [25:0]      id_jidx,
    output logic [31:0]      pc_o,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             br_wait_o,
    output logic [CNT_W-1:0] taken_cnt
);

    br_state_t   state, stateNext;
    logic [31:0] pcNext;
    logic [31:0] brTgt, jTgt;
    logic        takenInc;

    branch_target_calc uTgt (
        .idPc4   (id_pc4),
        .idImm16 (id_imm16),
        .idJidx  (id_jidx),
        .brTgt   (brTgt),
        .jTgt    (jTgt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            pc_o      <= RESET_PC;
            taken_cnt <= '0;
        end else begin
            state <= stateNext;
            pc_o  <= pcNext;
            if (takenInc)
                taken_cnt <= taken_cnt + CNT_W'(1);
        end
    end

    assign br_wait_o = (state == BR_WAIT);

    // BR_WAIT resolves on opnd_ready alone; the waiting beq is still in ID.
    always_comb begin
        stateNext   = state;
        pcNext      = pc_o;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        takenInc    = 1'b0;
        if (!rst && !stall_i) begin
            if (state == BR_WAIT || id_is_beq) begin
                if (!opnd_ready) begin
                    stateNext = BR_WAIT;
                end else begin
                    stateNext = RUN;
                    if_id_en  = 1'b1;
                    if (res_beq) begin
                        pcNext      = brTgt;
                        if_id_flush = 1'b1;
                        takenInc    = 1'b1;
                    end else begin
                        pcNext = pc_o + 32'(PC_STEP);
                    end
                end
            end else if (id_is_j) begin
                pcNext      = jTgt;
                if_id_en    = 1'b1;
                if_id_flush = 1'b1;
                takenInc    = 1'b1;
            end else begin
                pcNext   = pc_o + 32'(PC_STEP);
                if_id_en = 1'b1;
            end
        end
    end

    // beq and j decoded together means the decoder is broken.
    assert property (@(posedge clk) disable iff (rst) !(id_is_beq && id_is_j))
        else $error("branch_pc_ctrl: id_is_beq and id_is_j both asserted");

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Directed bench for branch_pc_ctrl: reset, beq/j redirects, operand wait, stall priority, wrap.
module tb_branch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, id_is_beq, id_is_j, opnd_ready, res_beq;
    logic [31:0] id_pc4;
    logic [15:0] id_imm16;
    logic [25:0] id_jidx;
    logic [31:0] pc_o;
    logic        if_id_en, if_id_flush, br_wait_o;
    logic [15:0] taken_cnt;

    int tests = 0;
    int fails = 0;

    branch_pc_ctrl #(.RESET_PC(32'h0000_3000), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall_i),
        .id_is_beq   (id_is_beq),
        .id_is_j     (id_is_j),
        .opnd_ready  (opnd_ready),
        .res_beq     (res_beq),
        .id_pc4      (id_pc4),
        .id_imm16    (id_imm16),
        .id_jidx     (id_jidx),
        .pc_o        (pc_o),
        .if_id_en    (if_id_en),
        .if_id_flush (if_id_flush),
        .br_wait_o   (br_wait_o),
        .taken_cnt   (taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_i = 0; id_is_beq = 0; id_is_j = 0; opnd_ready = 0; res_beq = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        id_pc4 = '0; id_imm16 = '0; id_jidx = '0;
        #2;
        chk("rst_pc", pc_o, 32'h3000);
        chk("rst_cnt", 32'(taken_cnt), 32'd0);
        chk("rst_en", 32'(if_id_en), 32'd0);
        chk("rst_flush", 32'(if_id_flush), 32'd0);
        chk("rst_wait", 32'(br_wait_o), 32'd0);
        step(); step();
        rst = 1'b0;
        #1;
        chk("run_en", 32'(if_id_en), 32'd1);
        chk("run_flush", 32'(if_id_flush), 32'd0);
        step(); chk("seq_3004", pc_o, 32'h3004);
        step(); chk("seq_3008", pc_o, 32'h3008);

        // taken beq: 0x3008 + (-2 << 2) = 0x3000
        id_is_beq = 1; opnd_ready = 1; res_beq = 1; id_pc4 = 32'h3008; id_imm16 = 16'hFFFE;
        #1;
        chk("tk_flush", 32'(if_id_flush), 32'd1);
        chk("tk_en", 32'(if_id_en), 32'd1);
        step(); chk("tk_pc", pc_o, 32'h3000); chk("tk_cnt", 32'(taken_cnt), 32'd1);

        // not-taken beq
        res_beq = 0; id_imm16 = 16'h0004;
        #1;
        chk("nt_flush", 32'(if_id_flush), 32'd0);
        chk("nt_en", 32'(if_id_en), 32'd1);
        step(); chk("nt_pc", pc_o, 32'h3004); chk("nt_cnt", 32'(taken_cnt), 32'd1);

        // jump: {0, 0xC40, 00} = 0x3100
        idle(); id_is_j = 1; id_pc4 = 32'h3010; id_jidx = 26'h0000C40;
        #1;
        chk("j_flush", 32'(if_id_flush), 32'd1);
        step(); chk("j_pc", pc_o, 32'h3100); chk("j_cnt", 32'(taken_cnt), 32'd2);

        // operand wait: two cycles not ready, then taken
        idle(); id_is_beq = 1; res_beq = 1; id_pc4 = 32'h3008; id_imm16 = 16'hFFFE;
        #1;
        chk("w0_en", 32'(if_id_en), 32'd0);
        chk("w0_flush", 32'(if_id_flush), 32'd0);
        chk("w0_wait", 32'(br_wait_o), 32'd0);
        step();
        chk("w1_pc", pc_o, 32'h3100);
        chk("w1_wait", 32'(br_wait_o), 32'd1);
        chk("w1_en", 32'(if_id_en), 32'd0);
        opnd_ready = 1;
        #1;
        chk("w2_wait", 32'(br_wait_o), 32'd1);
        chk("w2_flush", 32'(if_id_flush), 32'd1);
        chk("w2_en", 32'(if_id_en), 32'd1);
        step();
        chk("w3_pc", pc_o, 32'h3000);
        chk("w3_wait", 32'(br_wait_o), 32'd0);
        chk("w3_cnt", 32'(taken_cnt), 32'd3);

        // stall overrides a taken beq: target 0x3020 + 0x40 = 0x3060
        stall_i = 1; id_pc4 = 32'h3020; id_imm16 = 16'h0010;
        #1;
        chk("st_en", 32'(if_id_en), 32'd0);
        chk("st_flush", 32'(if_id_flush), 32'd0);
        step(); chk("st_pc", pc_o, 32'h3000); chk("st_cnt", 32'(taken_cnt), 32'd3);
        stall_i = 0;
        #1;
        chk("st_rel_flush", 32'(if_id_flush), 32'd1);
        step(); chk("st_rel_pc", pc_o, 32'h3060); chk("st_rel_cnt", 32'(taken_cnt), 32'd4);

        // PC wrap: jump to 0xFFFF_FFFC, then sequential to 0
        idle(); id_is_j = 1; id_pc4 = 32'hF000_0000; id_jidx = 26'h3FF_FFFF;
        step(); chk("wr_pc", pc_o, 32'hFFFF_FFFC);
        idle();
        step(); chk("wr_zero", pc_o, 32'h0000_0000);

        // reset while in BR_WAIT
        id_is_beq = 1; opnd_ready = 0;
        step(); chk("rw_wait", 32'(br_wait_o), 32'd1);
        #2 rst = 1;
        #1;
        chk("rw_pc", pc_o, 32'h3000);
        chk("rw_cnt", 32'(taken_cnt), 32'd0);
        chk("rw_wait0", 32'(br_wait_o), 32'd0);
        chk("rw_en", 32'(if_id_en), 32'd0);
        idle();
        step();
        rst = 0;
        step(); chk("rw_seq", pc_o, 32'h3004);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
